// File: rtl/ticket_arbiter.sv
// Round-robin arbiter sharing one queue-FIFO write port between three ticket kiosks.
// Each grant writes {ticket number, service time}, then holds one cycle so the next decision sees an updated full.
module ticket_arbiter #(
  parameter int NUM_W  = 4,
  parameter int TIME_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        req_in,
  input  logic [TIME_W-1:0] t0_in,
  input  logic [TIME_W-1:0] t1_in,
  input  logic [TIME_W-1:0] t2_in,
  input  logic              full,
  output logic              we_out,
  output logic [NUM_W-1:0]  wn_out,
  output logic [TIME_W-1:0] wt_out,
  output logic [2:0]        gnt_out,
  output logic [2:0]        rej_out,
  output logic [2:0]        pend_out,
  output logic [NUM_W-1:0]  next_num_out
);

  // state | meaning
  // IDLE  | may grant when not full and a kiosk is pending
  // HOLD  | write just issued; wait one cycle for full to reflect it
  typedef enum logic {IDLE, HOLD} state_t;

  state_t            state, state_n;
  logic [1:0]        ptr, ptr_n;
  logic [TIME_W-1:0] stime   [3];
  logic [TIME_W-1:0] stime_n [3];
  logic [TIME_W-1:0] t_in    [3];
  logic [2:0]        pend_n, gnt_n, rej_n;
  logic [NUM_W-1:0]  num_n, wn_n;
  logic [TIME_W-1:0] wt_n;
  logic              we_n, grant;
  logic [1:0]        gsel;

  assign t_in[0] = t0_in;
  assign t_in[1] = t1_in;
  assign t_in[2] = t2_in;

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    num_n   = next_num_out;
    pend_n  = pend_out;
    stime_n = stime;
    we_n    = 1'b0;
    gnt_n   = 3'b000;
    rej_n   = 3'b000;
    wn_n    = '0;
    wt_n    = '0;
    grant   = 1'b0;
    gsel    = 2'd0;

    if (state == HOLD) begin
      state_n = IDLE;
    end else if (!full && (|pend_out)) begin
      grant = 1'b1;
      // walk offsets from far to near so the kiosk closest to the pointer wins
      for (int i = 2; i >= 0; i--) begin
        if (pend_out[(int'(ptr) + i) % 3]) gsel = 2'((int'(ptr) + i) % 3);
      end
    end

    if (grant) begin
      state_n = HOLD;
      we_n    = 1'b1;
      gnt_n   = 3'b001 << gsel;
      wn_n    = next_num_out;
      wt_n    = stime[gsel];
      ptr_n   = (gsel == 2'd2) ? 2'd0 : gsel + 2'd1;
      num_n   = (next_num_out == '1) ? NUM_W'(1) : next_num_out + NUM_W'(1);
    end

    for (int k = 0; k < 3; k++) begin
      if (req_in[k]) begin
        if (!pend_out[k] || gnt_n[k]) begin
          pend_n[k]  = 1'b1;
          stime_n[k] = (t_in[k] == '0) ? TIME_W'(1) : t_in[k];
        end else begin
          rej_n[k] = 1'b1;
        end
      end else if (gnt_n[k]) begin
        pend_n[k] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      ptr          <= 2'd0;
      next_num_out <= NUM_W'(1);
      pend_out     <= 3'b000;
      we_out       <= 1'b0;
      gnt_out      <= 3'b000;
      rej_out      <= 3'b000;
      wn_out       <= '0;
      wt_out       <= '0;
      for (int k = 0; k < 3; k++) stime[k] <= TIME_W'(1);
    end else begin
      state        <= state_n;
      ptr          <= ptr_n;
      next_num_out <= num_n;
      pend_out     <= pend_n;
      we_out       <= we_n;
      gnt_out      <= gnt_n;
      rej_out      <= rej_n;
      wn_out       <= wn_n;
      wt_out       <= wt_n;
      for (int k = 0; k < 3; k++) stime[k] <= stime_n[k];
    end
  end

endmodule

// File: tb/tb_ticket_arbiter.sv
// Self-checking bench for ticket_arbiter: cycle-level reference model plus directed scenarios.
module tb_ticket_arbiter;

  localparam int NUM_W  = 4;
  localparam int TIME_W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [2:0]        req_in;
  logic [TIME_W-1:0] t0_in, t1_in, t2_in;
  logic              full;
  logic              we_out;
  logic [NUM_W-1:0]  wn_out, next_num_out;
  logic [TIME_W-1:0] wt_out;
  logic [2:0]        gnt_out, rej_out, pend_out;

  ticket_arbiter #(.NUM_W(NUM_W), .TIME_W(TIME_W)) dut (
    .clk(clk), .rst(rst), .req_in(req_in),
    .t0_in(t0_in), .t1_in(t1_in), .t2_in(t2_in), .full(full),
    .we_out(we_out), .wn_out(wn_out), .wt_out(wt_out),
    .gnt_out(gnt_out), .rej_out(rej_out), .pend_out(pend_out),
    .next_num_out(next_num_out)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: pending kiosks, stored times, ticket counter, and the rule that
  // two writes can never land on consecutive cycles.
  bit m_valid = 0;
  bit m_pend [3];
  int m_t [3];
  int m_ptr, m_num;
  bit m_wrote_last;
  int e_we, e_wn, e_wt, e_gnt, e_rej;

  always @(posedge clk) begin
    int g;
    int tin [3];
    bit old_pend [3];
    tin[0] = int'(t0_in); tin[1] = int'(t1_in); tin[2] = int'(t2_in);
    if (rst) begin
      m_valid = 1;
      for (int k = 0; k < 3; k++) begin m_pend[k] = 0; m_t[k] = 1; end
      m_ptr = 0; m_num = 1; m_wrote_last = 0;
      e_we = 0; e_wn = 0; e_wt = 0; e_gnt = 0; e_rej = 0;
    end else if (m_valid) begin
      old_pend = m_pend;
      g = -1;
      if (!m_wrote_last && !full) begin
        for (int i = 0; i < 3; i++)
          if (g < 0 && old_pend[(m_ptr + i) % 3]) g = (m_ptr + i) % 3;
      end
      e_rej = 0;
      if (g >= 0) begin
        e_we = 1; e_gnt = 1 << g; e_wn = m_num; e_wt = m_t[g];
        m_num = (m_num == 15) ? 1 : m_num + 1;
        m_ptr = (g + 1) % 3;
      end else begin
        e_we = 0; e_gnt = 0; e_wn = 0; e_wt = 0;
      end
      m_wrote_last = (g >= 0);
      for (int k = 0; k < 3; k++) begin
        if (req_in[k]) begin
          if (!old_pend[k] || k == g) begin
            m_pend[k] = 1;
            m_t[k] = (tin[k] == 0) ? 1 : tin[k];
          end else begin
            e_rej |= (1 << k);
          end
        end else if (k == g) begin
          m_pend[k] = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("we_out", int'(we_out), e_we);
      chk("wn_out", int'(wn_out), e_wn);
      chk("wt_out", int'(wt_out), e_wt);
      chk("gnt_out", int'(gnt_out), e_gnt);
      chk("rej_out", int'(rej_out), e_rej);
      chk("pend_out", int'(pend_out), {29'd0, m_pend[2], m_pend[1], m_pend[0]});
      chk("next_num_out", int'(next_num_out), m_num);
    end
  end

  task automatic step(input bit r, input logic [2:0] q, input int a, input int b,
                      input int c, input bit f);
    rst = r; req_in = q; full = f;
    t0_in = TIME_W'(a); t1_in = TIME_W'(b); t2_in = TIME_W'(c);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input bit f);
    step(0, 3'b000, 0, 0, 0, f);
  endtask

  initial begin
    int rr_t [3];
    rr_t[0] = 3; rr_t[1] = 4; rr_t[2] = 6;
    rst = 1; req_in = 0; full = 0; t0_in = 0; t1_in = 0; t2_in = 0;
    @(negedge clk);
    step(1, 3'b000, 0, 0, 0, 0);
    chk("reset next_num", int'(next_num_out), 1);
    chk("reset we", int'(we_out), 0);
    chk("reset pend", int'(pend_out), 0);

    // single request
    step(0, 3'b001, 5, 0, 0, 0);
    chk("single pend", int'(pend_out), 1);
    chk("single no early write", int'(we_out), 0);
    idle(0);
    chk("single we", int'(we_out), 1);
    chk("single gnt", int'(gnt_out), 1);
    chk("single wn", int'(wn_out), 1);
    chk("single wt", int'(wt_out), 5);
    chk("single next_num", int'(next_num_out), 2);
    idle(0);
    chk("single hold", int'(we_out), 0);

    // round robin from pointer 0
    step(1, 3'b000, 0, 0, 0, 0);
    step(0, 3'b111, 3, 4, 6, 0);
    for (int j = 0; j < 3; j++) begin
      idle(0);
      chk("rr gnt", int'(gnt_out), 1 << j);
      chk("rr wn", int'(wn_out), j + 1);
      chk("rr wt", int'(wt_out), rr_t[j]);
      idle(0);
      chk("rr hold", int'(we_out), 0);
    end

    // full stall
    step(0, 3'b011, 7, 2, 0, 1);
    repeat (9) idle(1);
    chk("stall pend", int'(pend_out), 3);
    chk("stall we", int'(we_out), 0);
    idle(0);
    chk("stall release gnt", int'(gnt_out), 1);
    chk("stall release wn", int'(wn_out), 4);
    chk("stall release wt", int'(wt_out), 7);
    idle(0);
    idle(0);
    chk("stall second gnt", int'(gnt_out), 2);
    chk("stall second wn", int'(wn_out), 5);
    chk("stall second wt", int'(wt_out), 2);
    idle(0);

    // reject, then re-request in the grant cycle
    step(0, 3'b010, 0, 9, 0, 1);
    step(0, 3'b010, 0, 12, 0, 1);
    chk("reject rej", int'(rej_out), 2);
    chk("reject pend", int'(pend_out), 2);
    idle(1);
    chk("reject one cycle", int'(rej_out), 0);
    step(0, 3'b010, 0, 11, 0, 0);
    chk("regrant gnt", int'(gnt_out), 2);
    chk("regrant old time", int'(wt_out), 9);
    chk("regrant wn", int'(wn_out), 6);
    chk("regrant pend kept", int'(pend_out), 2);
    chk("regrant no rej", int'(rej_out), 0);
    idle(0);
    idle(0);
    chk("rerequest gnt", int'(gnt_out), 2);
    chk("rerequest new time", int'(wt_out), 11);
    chk("rerequest wn", int'(wn_out), 7);
    idle(0);
    chk("rerequest pend clear", int'(pend_out), 0);

    // zero time clamp and ticket wrap
    step(1, 3'b000, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      step(0, 3'b001, 0, 0, 0, 0);
      idle(0);
      chk("wrap we", int'(we_out), 1);
      chk("wrap wn", int'(wn_out), (i % 15) + 1);
      chk("wrap wt clamp", int'(wt_out), 1);
      idle(0);
    end

    // reset while in HOLD with two kiosks pending
    step(0, 3'b001, 3, 0, 0, 0);
    step(0, 3'b110, 0, 2, 3, 0);
    chk("midrst write", int'(wn_out), 2);
    chk("midrst pend", int'(pend_out), 6);
    step(1, 3'b000, 0, 0, 0, 0);
    chk("midrst pend", int'(pend_out), 0);
    chk("midrst next_num", int'(next_num_out), 1);
    chk("midrst we", int'(we_out), 0);
    chk("midrst wn", int'(wn_out), 0);
    repeat (4) begin
      idle(0);
      chk("midrst quiet", int'(we_out), 0);
    end
    step(0, 3'b001, 4, 0, 0, 0);
    idle(0);
    chk("post rst wn", int'(wn_out), 1);
    chk("post rst wt", int'(wt_out), 4);
    idle(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
